fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 153 +++++++++++++++
 tb/tb_fifo_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: controller for a FIFO built on an external dual-port RAM with
// registered read data. Port A writes, port B reads. A two-entry output
// stage (output register plus skid register) hides the one-cycle RAM read
// latency, so one push and one pop can both happen on every cycle.
module fifo_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  // push side
  input  logic                 wr_en,
  input  logic [DATAWIDTH-1:0] wr_data,
  output logic                 full,
  // pop side
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATAWIDTH-1:0] rd_data,
  // status
  output logic                 empty,
  output logic [ADDRWIDTH+1:0] level,
  output logic                 overflow,
  // RAM side
  output logic [ADDRWIDTH-1:0] ram_address_a,
  output logic [DATAWIDTH-1:0] ram_data_a,
  output logic                 ram_wren_a,
  output logic [ADDRWIDTH-1:0] ram_address_b,
  output logic [DATAWIDTH-1:0] ram_data_b,
  output logic                 ram_wren_b,
  input  logic [DATAWIDTH-1:0] ram_q_b
);

  // ram_count value when every RAM slot holds an unfetched word
  localparam logic [ADDRWIDTH:0] RamFull = {1'b1, {ADDRWIDTH{1'b0}}};

  logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRWIDTH:0]   ram_count_q, ram_count_d;
  logic                 pending_q, pending_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATAWIDTH-1:0] out_data_q, out_data_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [DATAWIDTH-1:0] skid_data_q, skid_data_d;
  logic                 overflow_q, overflow_d;

  logic       push;
  logic       pop;
  logic       fetch;
  logic [1:0] occ_after_pop;

  assign full     = (ram_count_q == RamFull);
  assign push     = wr_en & ~full;
  assign pop      = out_valid_q & rd_ready;
  assign rd_valid = out_valid_q;
  assign rd_data  = out_data_q;
  assign overflow = overflow_q;

  assign level = (ADDRWIDTH+2)'(ram_count_q) + (ADDRWIDTH+2)'(pending_q)
               + (ADDRWIDTH+2)'(out_valid_q) + (ADDRWIDTH+2)'(skid_valid_q);
  assign empty = (level == '0);

  // Port A writes pushes straight through; port B always addresses the head.
  assign ram_address_a = wr_ptr_q;
  assign ram_data_a    = wr_data;
  assign ram_wren_a    = push;
  assign ram_address_b = rd_ptr_q;
  assign ram_data_b    = '0;
  assign ram_wren_b    = 1'b0;

  // Fetch only when the output stage will have room for the returning word.
  // A word written at edge k is counted in ram_count_q only after edge k, so
  // the earliest fetch of it is edge k+1 and port B never races port A.
  always_comb begin
    occ_after_pop = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(pending_q) - 2'(pop);
    fetch         = (ram_count_q != '0) && (occ_after_pop < 2'd2);
  end

  // Next-state logic for pointers, counters and the output/skid stage.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ram_count_d  = ram_count_q;
    pending_d    = fetch;
    overflow_d   = overflow_q | (wr_en & full);
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (push)  wr_ptr_d = wr_ptr_q + ADDRWIDTH'(1);
    if (fetch) rd_ptr_d = rd_ptr_q + ADDRWIDTH'(1);

    unique case ({push, fetch})
      2'b10:   ram_count_d = ram_count_q + (ADDRWIDTH+1)'(1);
      2'b01:   ram_count_d = ram_count_q - (ADDRWIDTH+1)'(1);
      default: ram_count_d = ram_count_q;
    endcase

    // Pop first: the skid word (older) refills the output register.
    if (pop) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // Then land the returning RAM word behind whatever is still held.
    if (pending_q) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_q_b;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = ram_q_b;
      end
    end
  end

  // Control state register; reset and flush clear everything, dropping any in-flight read.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset || flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      pending_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Skid data register.
  always_ff @(posedge clock) begin
    // NOTE: data-only storage is left unreset; skid_valid_q qualifies it, saving reset fan-out.
    skid_data_q <= skid_data_d;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl with a behavioural
// dual-port RAM (registered port-B read) and a queue scoreboard.
module tb_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int LW    = AW + 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic [AW-1:0] ram_address_a;
  logic [DW-1:0] ram_data_a;
  logic          ram_wren_a;
  logic [AW-1:0] ram_address_b;
  logic [DW-1:0] ram_data_b;
  logic          ram_wren_b;
  logic [DW-1:0] ram_q_b;

  int total = 0;
  int bad   = 0;
  int popped = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] wptr_m = '0;

  fifo_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .empty(empty), .level(level), .overflow(overflow),
    .ram_address_a(ram_address_a), .ram_data_a(ram_data_a), .ram_wren_a(ram_wren_a),
    .ram_address_b(ram_address_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
    .ram_q_b(ram_q_b)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: write on port A, registered read on port B.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    ram_q_b <= mem[ram_address_b];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs at the negedge, check, advance the scoreboard.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic rr, input logic fl);
    logic acc, pp;
    wr_en = we; wr_data = wd; rd_ready = rr; flush = fl;
    #1;
    total++;
    if (level !== LW'(exp_q.size())) begin
      bad++; $display("FAIL level: got %0d want %0d", level, exp_q.size());
    end
    total++;
    if (empty !== (exp_q.size() == 0)) begin
      bad++; $display("FAIL empty: got %0b want %0b", empty, exp_q.size() == 0);
    end
    total++;
    if (ram_wren_a !== (we & ~full)) begin
      bad++; $display("FAIL ram_wren_a: got %0b want %0b", ram_wren_a, we & ~full);
    end
    acc = we && !full && !fl;
    if (acc) begin
      total++;
      if (ram_address_a !== wptr_m || ram_data_a !== wd) begin
        bad++; $display("FAIL ram_port_a: got addr=%0d data=%h want addr=%0d data=%h",
                        ram_address_a, ram_data_a, wptr_m, wd);
      end
    end
    if (rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL rd_valid: got 1 want 0 (scoreboard empty)");
      end else if (rd_data !== exp_q[0]) begin
        bad++; $display("FAIL rd_data: got %h want %h", rd_data, exp_q[0]);
      end
    end
    pp = rd_valid && rr && !fl;
    @(posedge clock);
    if (fl) begin
      exp_q.delete();
      wptr_m = '0;
    end else begin
      if (pp) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (acc) begin
        exp_q.push_back(wd);
        wptr_m = wptr_m + AW'(1);
      end
    end
    @(negedge clock);
    wr_en = 1'b0; rd_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_timeout: got %0d words left want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'h77; rd_ready = 1'b1;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    reset = 1'b0; wr_en = 1'b0; rd_ready = 1'b0;
    exp_q.delete(); wptr_m = '0;
    #1;
    total++; if (level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %0b want 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", full); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    total++;
    if (ram_wren_b !== 1'b0 || ram_data_b !== '0) begin
      bad++; $display("FAIL port_b_tie: got wren=%0b data=%h want 0/00", ram_wren_b, ram_data_b);
    end
    @(negedge clock);
  endtask

  task automatic test_first_word();
    cycle(1'b1, 8'h11, 1'b0, 1'b0);        // push at edge k
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL first_k0_valid: got %0b want 0", rd_valid); end
    cycle(1'b0, '0, 1'b0, 1'b0);           // edge k+1
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL first_k1_valid: got %0b want 0", rd_valid); end
    cycle(1'b0, '0, 1'b0, 1'b0);           // edge k+2
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL first_k2_valid: got %0b want 1", rd_valid); end
    total++; if (rd_data !== 8'h11) begin bad++; $display("FAIL first_k2_data: got %h want 11", rd_data); end
    total++; if (level !== LW'(1)) begin bad++; $display("FAIL first_level: got %0d want 1", level); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL first_empty: got %0b want 0", empty); end
    drain();
  endtask

  task automatic test_full_overflow();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_after6: got %0b want 1", full); end
    total++; if (level !== LW'(6)) begin bad++; $display("FAIL level_after6: got %0d want 6", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before7: got %0b want 0", overflow); end
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_after7: got %0b want 1", overflow); end
    total++; if (level !== LW'(6)) begin bad++; $display("FAIL level_after7: got %0d want 6", level); end
    drain();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_after_drain: got %0b want 1", empty); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_flush: got %0b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    int start = popped;
    for (int i = 0; i < 256; i++) begin
      if (i >= 3) begin
        total++;
        if (rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_bubble: cycle %0d got rd_valid=%0b want 1", i, rd_valid); end
      end
      cycle(1'b1, DW'(i), 1'b1, 1'b0);
    end
    drain();
    total++;
    if (popped - start != 256) begin bad++; $display("FAIL b2b_count: got %0d words want 256", popped - start); end
  endtask

  task automatic test_random();
    logic prev_ovf = 1'b0;
    logic tried_full;
    logic we, rr;
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      we = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < (((i / 500) % 2 == 0) ? 70 : 25));
      total++;
      if (full && exp_q.size() < DEPTH) begin
        bad++; $display("FAIL rand_full: got full=1 want 0 at model level %0d", exp_q.size());
      end
      tried_full = we && full;
      cycle(we, DW'($urandom), rr, 1'b0);
      total++;
      if (overflow && !prev_ovf && !tried_full) begin
        bad++; $display("FAIL rand_overflow: got 1 want 0 (no refused push)");
      end
      prev_ovf = overflow;
    end
    drain();
  endtask

  task automatic test_flush_inflight();
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 8'h30, 1'b0, 1'b0);
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);   // fetch of 0x31 in flight after this edge
    cycle(1'b0, '0, 1'b0, 1'b1);
    total++; if (level !== '0) begin bad++; $display("FAIL flush_level: got %0d want 0", level); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL flush_rd_valid: got %0b want 0", rd_valid); end
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL flush_next_valid: got %0b want 1", rd_valid); end
    total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL flush_next_data: got %h want a5", rd_data); end
    drain();
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_full_overflow();
    test_back_to_back();
    test_random();
    test_flush_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
